// File: rtl/rf_pkg.sv
// Shared definitions for the register-file writeback scheduler.
// Holds the default widths, the writeback request bundle and the
// grant encoding used by the round-robin arbiter.
package rf_pkg;

   localparam int BIT_NUMBER      = 64;
   localparam int ADDR_NUMBER     = 5;
   localparam int REGISTER_NUMBER = 16;
   localparam int REG_IDX_W       = $clog2(REGISTER_NUMBER);

   typedef struct packed {
      logic                   valid;
      logic [ADDR_NUMBER-1:0] dest;
      logic [BIT_NUMBER-1:0]  data;
   } wb_req_t;

   typedef enum logic {
      GRANT_ALU = 1'b0,
      GRANT_MEM = 1'b1
   } grant_e;

   // Addresses at or above REGISTER_NUMBER have no backing register.
   function automatic logic inRange(input logic [ADDR_NUMBER-1:0] addr);
      return int'(addr) < REGISTER_NUMBER;
   endfunction

endpackage

// File: rtl/rf_wb_scheduler_if.sv
// Bundle of the scheduler's issue, writeback and register-file signals.
// master: the surrounding pipeline (decode, ALU, load unit, register file).
// slave : the scheduler itself.
//   issue_*  : decode issue request and stall feedback
//   alu_*    : ALU writeback request/grant
//   mem_*    : load writeback request/grant
//   rf_*     : registered write port towards the register file
//   busy_mask, err_oob : scoreboard view and sticky out-of-range flag
interface rf_wb_if;
   import rf_pkg::*;

   logic                       issue_valid;
   logic [ADDR_NUMBER-1:0]     issue_src1;
   logic [ADDR_NUMBER-1:0]     issue_src2;
   logic [ADDR_NUMBER-1:0]     issue_dest;
   logic                       issue_ready;

   logic                       alu_valid;
   logic [ADDR_NUMBER-1:0]     alu_dest;
   logic [BIT_NUMBER-1:0]      alu_data;
   logic                       alu_ready;

   logic                       mem_valid;
   logic [ADDR_NUMBER-1:0]     mem_dest;
   logic [BIT_NUMBER-1:0]      mem_data;
   logic                       mem_ready;

   logic                       rf_write_enable;
   logic [ADDR_NUMBER-1:0]     rf_dest_addr;
   logic [BIT_NUMBER-1:0]      rf_write_data;
   logic [REGISTER_NUMBER-1:0] busy_mask;
   logic                       err_oob;

   modport master (
      output issue_valid, issue_src1, issue_src2, issue_dest,
      input  issue_ready,
      output alu_valid, alu_dest, alu_data,
      input  alu_ready,
      output mem_valid, mem_dest, mem_data,
      input  mem_ready,
      input  rf_write_enable, rf_dest_addr, rf_write_data, busy_mask, err_oob
   );

   modport slave (
      input  issue_valid, issue_src1, issue_src2, issue_dest,
      output issue_ready,
      input  alu_valid, alu_dest, alu_data,
      output alu_ready,
      input  mem_valid, mem_dest, mem_data,
      output mem_ready,
      output rf_write_enable, rf_dest_addr, rf_write_data, busy_mask, err_oob
   );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
//   clk, reset : clock and synchronous active-high reset
//   req_i[0]   : ALU request, req_i[1] : load request
//   gnt_o      : one-hot grant, all zero while reset is high
module rr_arbiter2
   import rf_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   grant_e lastGrant_q, lastGrant_d;

   // Remember who won most recently; reset favours the ALU on the first tie.
   always_ff @(posedge clk) begin
      if (reset) begin
         lastGrant_q <= GRANT_MEM;
      end else begin
         lastGrant_q <= lastGrant_d;
      end
   end

   // On a tie the requester that did not win last time takes the port.
   always_comb begin
      gnt_o       = 2'b00;
      lastGrant_d = lastGrant_q;
      if (!reset) begin
         if (req_i[0] && (!req_i[1] || lastGrant_q == GRANT_MEM)) begin
            gnt_o       = 2'b01;
            lastGrant_d = GRANT_ALU;
         end else if (req_i[1]) begin
            gnt_o       = 2'b10;
            lastGrant_d = GRANT_MEM;
         end
      end
   end

endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file scoreboard and write-port scheduler.
// Stalls issue on RAW/WAW hazards against in-flight results and shares
// the single register-file write port between ALU and load writeback.
//   clk, reset : clock and synchronous active-high reset
//   bus        : rf_wb_if slave (issue, alu, mem, rf write port, status)
module rf_wb_scheduler
   import rf_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   rf_wb_if.slave   bus
);

   logic [REGISTER_NUMBER-1:0] busy_q, busy_d;
   logic                       rfWe_q, rfWe_d;
   logic [ADDR_NUMBER-1:0]     rfAddr_q, rfAddr_d;
   logic [BIT_NUMBER-1:0]      rfData_q, rfData_d;
   logic                       errOob_q, errOob_d;

   wb_req_t    aluReq, memReq, winReq;
   logic [1:0] gnt;
   logic       issueFire;

   function automatic logic isBusy(input logic [REGISTER_NUMBER-1:0] mask,
                                   input logic [ADDR_NUMBER-1:0] addr);
      return inRange(addr) && mask[addr[REG_IDX_W-1:0]];
   endfunction

   assign aluReq = '{valid: bus.alu_valid, dest: bus.alu_dest, data: bus.alu_data};
   assign memReq = '{valid: bus.mem_valid, dest: bus.mem_dest, data: bus.mem_data};

   rr_arbiter2 uArb (
      .clk   (clk),
      .reset (reset),
      .req_i ({memReq.valid, aluReq.valid}),
      .gnt_o (gnt)
   );

   assign bus.alu_ready = gnt[0];
   assign bus.mem_ready = gnt[1];
   assign winReq        = gnt[1] ? memReq : aluReq;

   // Issue is blocked if any operand or the destination still awaits a result.
   assign bus.issue_ready = !reset &&
                            !(isBusy(busy_q, bus.issue_src1) ||
                              isBusy(busy_q, bus.issue_src2) ||
                              isBusy(busy_q, bus.issue_dest));
   assign issueFire = bus.issue_valid && bus.issue_ready;

   // Clear the bit being written this cycle, then apply a new issue so that
   // a same-register set overrides the clear.
   always_comb begin
      busy_d = busy_q;
      if (rfWe_q) begin
         busy_d[rfAddr_q[REG_IDX_W-1:0]] = 1'b0;
      end
      if (issueFire && inRange(bus.issue_dest)) begin
         busy_d[bus.issue_dest[REG_IDX_W-1:0]] = 1'b1;
      end
   end

   // Load the write port from the granted request; an out-of-range target is
   // dropped and only leaves the sticky error behind.
   always_comb begin
      rfWe_d   = 1'b0;
      rfAddr_d = rfAddr_q;
      rfData_d = rfData_q;
      errOob_d = errOob_q;
      if (|gnt) begin
         if (inRange(winReq.dest)) begin
            rfWe_d   = 1'b1;
            rfAddr_d = winReq.dest;
            rfData_d = winReq.data;
         end else begin
            errOob_d = 1'b1;
         end
      end
   end

   // All state updates on posedge so the negedge-write register file sees
   // settled values.
   always_ff @(posedge clk) begin
      if (reset) begin
         busy_q   <= '0;
         rfWe_q   <= 1'b0;
         rfAddr_q <= '0;
         rfData_q <= '0;
         errOob_q <= 1'b0;
      end else begin
         busy_q   <= busy_d;
         rfWe_q   <= rfWe_d;
         rfAddr_q <= rfAddr_d;
         rfData_q <= rfData_d;
         errOob_q <= errOob_d;
      end
   end

   assign bus.rf_write_enable = rfWe_q;
   assign bus.rf_dest_addr    = rfAddr_q;
   assign bus.rf_write_data   = rfData_q;
   assign bus.busy_mask       = busy_q;
   assign bus.err_oob         = errOob_q;

endmodule

// File: doc/rf_wb_scheduler.md
# rf_wb_scheduler

Register-file scoreboard and write-port scheduler. It tracks which architectural registers have a result in flight and stalls instruction issue on RAW and WAW hazards. It also arbitrates the single register-file write port between the ALU and memory-load writeback paths using round-robin. It drives the register file's write_enable, dest_addr and write_data from registers clocked on posedge, so the negedge-write register file always samples stable values.

## Interface
- BIT_NUMBER, 64, data width.
- ADDR_NUMBER, 5, register address width.
- REGISTER_NUMBER, 16, number of implemented registers; addresses >= REGISTER_NUMBER are out of range.

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- issue_valid  in  1  decode has an instruction to issue.
- issue_src1, issue_src2, issue_dest  in  ADDR_NUMBER  operand and destination addresses.
- issue_ready  out  1  issue accepted this cycle when issue_valid & issue_ready.
- alu_valid  in  1  ALU writeback request.
- alu_dest  in  ADDR_NUMBER  ALU destination address.
- alu_data  in  BIT_NUMBER  ALU result.
- alu_ready  out  1  ALU grant.
- mem_valid, mem_dest, mem_data, mem_ready  same as alu_*, for the load path.
- rf_write_enable  out  1  to register file.
- rf_dest_addr  out  ADDR_NUMBER  to register file.
- rf_write_data  out  BIT_NUMBER  to register file.
- busy_mask  out  REGISTER_NUMBER  scoreboard; bit i set means register i has a pending write.
- err_oob  out  1  sticky flag: an out-of-range writeback was dropped.

## Operation
- The scoreboard is busy[REGISTER_NUMBER]. busy(a) = 0 for out-of-range a.
- issue_ready is combinational: !(busy(issue_src1) | busy(issue_src2) | busy(issue_dest)). It is independent of issue_valid.
- An issue fires when issue_valid & issue_ready. It sets busy[issue_dest] at the next posedge; an out-of-range dest sets nothing.
- Arbitration is round-robin with one last_grant bit.
  - If both requesters are valid, the one not granted last wins.
  - If only one is valid, it wins and last_grant updates.
  - alu_ready and mem_ready are combinational; at most one is high per cycle, and only alongside its own valid.
- On a grant, the output registers load at the next posedge:
  - rf_write_enable = 1 (0 if dest is out of range).
  - rf_dest_addr and rf_write_data take the granted dest and data.
  - An out-of-range dest instead sets err_oob.
- With no grant, rf_write_enable = 0 and rf_dest_addr/rf_write_data hold their values.
- busy[rf_dest_addr] clears at the posedge that ends a cycle where rf_write_enable = 1.
- Same-register set and clear in one cycle: set wins. This only occurs when a writeback hits a non-busy register, which is allowed and performed.
- Reset:
  - busy_mask = 0, rf_write_enable = 0, rf_dest_addr = 0, rf_write_data = 0.
  - last_grant = mem, so the ALU wins the first tie.
  - err_oob = 0.
  - In-flight grants are discarded; ready outputs are 0 while reset is high.

## Timing
- Grant in cycle N gives rf_write_enable high in cycle N+1. The register file writes at the negedge inside N+1.
- busy clears at the end of N+1, so a dependent issue sees issue_ready = 1 in cycle N+2.
- Issue in cycle N makes busy visible from N+1. A back-to-back dependent issue stalls.
- Throughput is one writeback per cycle. A loser of a tie holds valid and is granted the next cycle if it remains valid.
- Requesters must hold valid, dest and data stable until ready.

## Structure
- A shared package `rf_pkg` holds:
  - default width constants (BIT_NUMBER, ADDR_NUMBER, REGISTER_NUMBER);
  - a `wb_req_t` struct {valid, dest, data};
  - a `grant_e` enum {GRANT_ALU, GRANT_MEM}.
- One sub-module, `rr_arbiter2`: 2-way round-robin, holding last_grant, with req[1:0] in and gnt[1:0] out.
- The scoreboard and output registers stay in the top level.

## Test plan
- Reset with everything idle: busy_mask = 0, rf_write_enable = 0, issue_ready = 1; with both requesters valid the first cycle after reset, alu_ready = 1 and mem_ready = 0.
- Issue with dest = 3, then an issue with src1 = 3: the second stalls. An ALU writeback to 3 with data 0xDEAD is granted in cycle N; rf_write_enable = 1, rf_dest_addr = 3 and rf_write_data = 0xDEAD in N+1; busy[3] = 0 and issue_ready = 1 in N+2.
- ALU and MEM both valid for 4 cycles: grants alternate ALU, MEM, ALU, MEM.
- MEM writeback to dest = 20 (out of range): mem_ready = 1, rf_write_enable stays 0 and err_oob = 1 until reset.
- Issue to dest = 5 is blocked while busy[5] = 1 (WAW stall); a writeback to non-busy register 7 in the same cycle as an issue to dest 7 leaves busy[7] = 1.
- Reset asserted with busy_mask = 0x00F0 and a grant pending: the next cycle shows busy_mask = 0 and rf_write_enable = 0.
